// File: rtl/dmux_stream_pkg.sv
// Shared definitions for the dmux_stream block: the FSM state encoding and
// the width of the optional dropped-beat counter.
package dmux_stream_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PKT  = 1'b1
    } state_e;

    localparam int DROP_CNT_W = 16;

endpackage

// File: rtl/dmux_stream_hold.sv
// Output holding register for dmux_stream: one beat of data/last/channel
// plus a full flag. A load wins over a drain in the same cycle, so a beat
// leaving and a beat arriving together keeps the register full.
module dmux_stream_hold
    import dmux_stream_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SEL_W = 3
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load_i,
    input  logic             drain_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             last_i,
    input  logic [SEL_W-1:0] chan_i,
    output logic             full_o,
    output logic [WIDTH-1:0] data_o,
    output logic             last_o,
    output logic [SEL_W-1:0] chan_o
);

    logic             full_q, full_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             last_q, last_d;
    logic [SEL_W-1:0] chan_q, chan_d;

    // Next-state: reload on an accepted routed beat, otherwise empty on drain.
    always_comb begin
        full_d = full_q;
        data_d = data_q;
        last_d = last_q;
        chan_d = chan_q;
        if (load_i) begin
            full_d = 1'b1;
            data_d = data_i;
            last_d = last_i;
            chan_d = chan_i;
        end else if (drain_i) begin
            full_d = 1'b0;
        end
    end

    // Holding register; everything clears on reset so outputs never carry X.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            full_q <= 1'b0;
            data_q <= '0;
            last_q <= 1'b0;
            chan_q <= '0;
        end else begin
            full_q <= full_d;
            data_q <= data_d;
            last_q <= last_d;
            chan_q <= chan_d;
        end
    end

    assign full_o = full_q;
    assign data_o = data_q;
    assign last_o = last_q;
    assign chan_o = chan_q;

endmodule

// File: rtl/dmux_stream.sv
// Registered 1-to-CHANNELS stream demultiplexer with per-packet route lock.
// The route is taken from in_sel on the first beat and held until in_last.
// Beats for a destination >= CHANNELS are accepted and discarded.
// Optional feature: define DMUX_STREAM_DROP_CNT_EN to add the saturating
// drop_count output counting discarded beats.
module dmux_stream
    import dmux_stream_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int CHANNELS = 8,
    parameter int SEL_W    = $clog2(CHANNELS)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [WIDTH-1:0]      in_data,
    input  logic [SEL_W-1:0]      in_sel,
    input  logic                  in_last,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [WIDTH-1:0]      out_data,
    output logic                  out_last,
    output logic [CHANNELS-1:0]   out_valid,
    input  logic [CHANNELS-1:0]   out_ready,
    output logic                  busy
`ifdef DMUX_STREAM_DROP_CNT_EN
    ,
    output logic [DROP_CNT_W-1:0] drop_count
`endif
);

    state_e           state_q, state_d;
    logic [SEL_W-1:0] cur_sel_q, cur_sel_d;

    logic             full;
    logic [SEL_W-1:0] hold_chan;
    logic             chan_rdy;
    logic [SEL_W-1:0] route_sel;
    logic             route_ok;
    logic             xfer;
    logic             load;
    logic             drain;

    // Ready of the sink the held beat is waiting on; a loop rather than an
    // index so a non-power-of-two channel count never reads past out_ready.
    always_comb begin
        chan_rdy = 1'b0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (hold_chan == SEL_W'(k)) chan_rdy = out_ready[k];
        end
    end

    assign in_ready  = !reset && (!full || chan_rdy);
    assign xfer      = in_valid && in_ready;
    assign route_sel = (state_q == ST_PKT) ? cur_sel_q : in_sel;
    assign route_ok  = ({1'b0, route_sel} < (SEL_W+1)'(CHANNELS));
    assign load      = xfer && route_ok;
    assign drain     = full && chan_rdy;
    assign busy      = (state_q == ST_PKT);

    // Packet FSM: open a packet on a non-last beat, close it on a last beat.
    always_comb begin
        state_d   = state_q;
        cur_sel_d = cur_sel_q;
        case (state_q)
            ST_IDLE: begin
                if (xfer && !in_last) begin
                    state_d   = ST_PKT;
                    cur_sel_d = in_sel;
                end
            end
            ST_PKT: begin
                if (xfer && in_last) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM state and locked route; reset abandons any open packet.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cur_sel_q <= '0;
        end else begin
            state_q   <= state_d;
            cur_sel_q <= cur_sel_d;
        end
    end

    dmux_stream_hold #(
        .WIDTH (WIDTH),
        .SEL_W (SEL_W)
    ) u_hold (
        .clock   (clock),
        .reset   (reset),
        .load_i  (load),
        .drain_i (drain),
        .data_i  (in_data),
        .last_i  (in_last),
        .chan_i  (route_sel),
        .full_o  (full),
        .data_o  (out_data),
        .last_o  (out_last),
        .chan_o  (hold_chan)
    );

    // One-hot decode of the held channel (DMux tree flattened into a loop).
    for (genvar k = 0; k < CHANNELS; k++) begin : g_valid
        assign out_valid[k] = full && (hold_chan == SEL_W'(k));
    end

`ifdef DMUX_STREAM_DROP_CNT_EN
    logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;

    // Count beats discarded for an out-of-range route, sticking at all-ones.
    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (xfer && !route_ok && (drop_cnt_q != '1)) drop_cnt_d = drop_cnt_q + 1'b1;
    end

    // Drop counter register; only reset clears it.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) drop_cnt_q <= '0;
        else       drop_cnt_q <= drop_cnt_d;
    end

    assign drop_count = drop_cnt_q;
`endif

endmodule
